// File: rtl/ai_move_scanner_if.sv
// Handshake/bus bundle between the game-control FSM (master) and the
// tic-tac-toe move scanner (slave). Suffixes are from the scanner's view:
// _i is driven by the master, _o is driven by the scanner.
interface ai_move_scanner_if #(
  parameter int N = 3
);
  localparam int CELLS = N * N;
  localparam int IDX_W = $clog2(CELLS);

  logic                 start_i;
  logic                 abort_i;
  logic [2*CELLS-1:0]   board_i;
  logic                 busy_o;
  logic                 done_o;
  logic [IDX_W-1:0]     move_o;
  logic [3:0]           move_score_o;
  logic                 no_move_o;
  logic                 bad_board_o;

  // Game-control side: issues requests, consumes results.
  modport master (
    output start_i, abort_i, board_i,
    input  busy_o, done_o, move_o, move_score_o, no_move_o, bad_board_o
  );

  // Scanner side: consumes requests, produces results.
  modport slave (
    input  start_i, abort_i, board_i,
    output busy_o, done_o, move_o, move_score_o, no_move_o, bad_board_o
  );
endinterface

// File: rtl/ai_move_scanner.sv
// ai_move_scanner: NxN tic-tac-toe move selector.
// On start the board is snapshotted and scanned one cell per clock. Each empty
// cell is scored (win 15 / block 12 / center 4 / corner 3 / other 1) and the
// best (strictly highest, lowest index on ties) is reported with a done pulse.
// Optional feature macro: AI_BLOCK_EN -- when defined, the score-12 "block the
// player's line" class is built; when undefined that logic is absent.
// Scoring is split into two register stages (candidate score, then fold into
// best) so the line-check logic and the compare/update do not share one path.
// This is why a scan takes CELLS+1 cycles in SCAN before DONE.
module ai_move_scanner #(
  parameter int         N           = 3,
  parameter logic [1:0] AI_CODE     = 2'b10,
  parameter logic [1:0] PLAYER_CODE = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
  ai_move_scanner_if.slave   bus
);

  localparam int CELLS  = N * N;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int K_W    = $clog2(CELLS + 1);  // k must reach CELLS (pipeline drain)
  localparam int RC_W   = $clog2(N);
  localparam int CTR_LO = (N - 1) / 2;
  localparam int CTR_HI = N / 2;

  localparam logic [1:0] EMPTY_CODE   = 2'b00;
  localparam logic [1:0] ILLEGAL_CODE = 2'b11;

  localparam logic [3:0] SCORE_WIN    = 4'd15;
  localparam logic [3:0] SCORE_BLOCK  = 4'd12;
  localparam logic [3:0] SCORE_CENTER = 4'd4;
  localparam logic [3:0] SCORE_CORNER = 4'd3;
  localparam logic [3:0] SCORE_OTHER  = 4'd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [2*CELLS-1:0]  snap_q;
  logic [K_W-1:0]      k_q;
  logic [RC_W-1:0]     row_q;
  logic [RC_W-1:0]     col_q;

  // Stage 1: score of the cell examined last cycle.
  logic                cand_valid_q;
  logic [3:0]          cand_score_q;
  logic [IDX_W-1:0]    cand_idx_q;

  // Stage 2: running best.
  logic [3:0]          best_score_q;
  logic [IDX_W-1:0]    best_idx_q;
  logic                bad_q;

  // Registered outputs.
  logic                busy_q;
  logic                done_q;
  logic [IDX_W-1:0]    move_q;
  logic [3:0]          move_score_q;
  logic                no_move_q;
  logic                bad_board_q;

  // Combinational scoring / fold results.
  logic [1:0]          cell_code;
  logic                cell_empty;
  logic                cell_bad;
  logic                win_hit;
  logic                block_hit;
  logic                is_center;
  logic                is_corner;
  logic [3:0]          cell_score;
  logic [3:0]          best_score_d;
  logic [IDX_W-1:0]    best_idx_d;
  logic                k_in_range;
  logic                last_col;
  logic                last_row;

  // True if placing `code` at (r,c) completes the row, column or a full-length
  // diagonal through (r,c), with every other cell of that line holding `code`.
  function automatic logic line_complete(
    input logic [2*CELLS-1:0] s,
    input logic [1:0]         code,
    input int                 r,
    input int                 c
  );
    logic row_ok;
    logic col_ok;
    logic dg_ok;
    logic ad_ok;
    row_ok = 1'b1;
    col_ok = 1'b1;
    dg_ok  = (r == c);
    ad_ok  = (r + c == N - 1);
    for (int j = 0; j < N; j++) begin
      if (j != c && s[2*(r*N + j) +: 2] != code) row_ok = 1'b0;
      if (j != r && s[2*(j*N + c) +: 2] != code) col_ok = 1'b0;
      if (j != r && s[2*(j*N + j) +: 2] != code) dg_ok = 1'b0;
      if (j != r && s[2*(j*N + (N - 1 - j)) +: 2] != code) ad_ok = 1'b0;
    end
    return row_ok | col_ok | dg_ok | ad_ok;
  endfunction

  // Score the cell at (row_q, col_q) against the snapshot with that cell as candidate.
  always_comb begin
    k_in_range = (int'(k_q) < CELLS);
    cell_code  = snap_q[2*(int'(row_q)*N + int'(col_q)) +: 2];
    cell_empty = (cell_code == EMPTY_CODE);
    cell_bad   = (cell_code == ILLEGAL_CODE);
    win_hit    = line_complete(snap_q, AI_CODE, int'(row_q), int'(col_q));
`ifdef AI_BLOCK_EN
    block_hit  = line_complete(snap_q, PLAYER_CODE, int'(row_q), int'(col_q));
`else
    block_hit  = 1'b0;
`endif
    is_center  = (int'(row_q) == CTR_LO || int'(row_q) == CTR_HI) &&
                 (int'(col_q) == CTR_LO || int'(col_q) == CTR_HI);
    is_corner  = (int'(row_q) == 0 || int'(row_q) == N - 1) &&
                 (int'(col_q) == 0 || int'(col_q) == N - 1);
    if (win_hit)         cell_score = SCORE_WIN;
    else if (block_hit)  cell_score = SCORE_BLOCK;
    else if (is_center)  cell_score = SCORE_CENTER;
    else if (is_corner)  cell_score = SCORE_CORNER;
    else                 cell_score = SCORE_OTHER;
    last_col   = (int'(col_q) == N - 1);
    last_row   = (int'(row_q) == N - 1);
  end

  // Fold the pending candidate into the best; strict > keeps the lowest index on ties.
  always_comb begin
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    if (cand_valid_q && (cand_score_q > best_score_q)) begin
      best_score_d = cand_score_q;
      best_idx_d   = cand_idx_q;
    end
  end

  // Scan FSM with all state, datapath and outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      k_q          <= '0;
      row_q        <= '0;
      col_q        <= '0;
      cand_valid_q <= 1'b0;
      cand_score_q <= '0;
      cand_idx_q   <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      bad_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      move_q       <= '0;
      move_score_q <= '0;
      no_move_q    <= 1'b0;
      bad_board_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          // start wins over a simultaneous abort here.
          if (bus.start_i) begin
            snap_q       <= bus.board_i;
            k_q          <= '0;
            row_q        <= '0;
            col_q        <= '0;
            cand_valid_q <= 1'b0;
            best_score_q <= '0;
            best_idx_q   <= '0;
            bad_q        <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (bus.abort_i) begin
            // Cancel silently; the previous result registers stay as they were.
            cand_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            best_score_q <= best_score_d;
            best_idx_q   <= best_idx_d;
            if (k_in_range) begin
              cand_valid_q <= cell_empty;
              cand_score_q <= cell_score;
              cand_idx_q   <= IDX_W'(k_q);
              if (cell_bad) bad_q <= 1'b1;
              k_q <= k_q + K_W'(1);
              // The position stays on the last row after the final cell so
              // the line check never indexes outside the board.
              if (last_col) begin
                col_q <= '0;
                if (!last_row) row_q <= row_q + RC_W'(1);
              end else begin
                col_q <= col_q + RC_W'(1);
              end
            end else begin
              // Pipeline drained: publish the result.
              cand_valid_q <= 1'b0;
              done_q       <= 1'b1;
              move_q       <= bad_q ? '0 : best_idx_d;
              move_score_q <= bad_q ? '0 : best_score_d;
              no_move_q    <= (best_score_d == 4'd0);
              bad_board_q  <= bad_q;
              state_q      <= S_DONE;
            end
          end
        end

        S_DONE: begin
          // Single done cycle; abort and start are not acted on here.
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.move_o       = move_q;
  assign bus.move_score_o = move_score_q;
  assign bus.no_move_o    = no_move_q;
  assign bus.bad_board_o  = bad_board_q;

endmodule

// File: tb/tb_ai_move_scanner.sv
// Directed testbench for ai_move_scanner (N=3 and N=4 instances).
// Expected values are hand-derived from the board layouts below.
module tb_ai_move_scanner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  localparam logic [1:0] AI  = 2'b10;
  localparam logic [1:0] PL  = 2'b01;
  localparam logic [1:0] BAD = 2'b11;

  ai_move_scanner_if #(.N(3)) bus3 ();
  ai_move_scanner_if #(.N(4)) bus4 ();

  ai_move_scanner #(.N(3), .AI_CODE(AI), .PLAYER_CODE(PL)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  ai_move_scanner #(.N(4), .AI_CODE(AI), .PLAYER_CODE(PL)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  function automatic logic [17:0] put3(input logic [17:0] b, input int k, input logic [1:0] c);
    logic [17:0] r;
    r = b;
    r[2*k +: 2] = c;
    return r;
  endfunction

  // Issue one start on the N=3 unit and wait (bounded) for done; lat counts
  // rising edges after the edge that sampled start.
  task automatic run3(input logic [17:0] b, output int lat);
    repeat (2) @(negedge clk);
    bus3.board_i = b;
    bus3.start_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_i = 1'b0;
    bus3.board_i = '1;
    lat = 0;
    while (lat < 40 && bus3.done_o !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("scan N=3 board=%h lat=%0d move=%0d score=%0d no_move=%0b bad=%0b",
             b, lat, bus3.move_o, bus3.move_score_o, bus3.no_move_o, bus3.bad_board_o);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus3.busy_o !== 1'b0 || bus3.done_o !== 1'b0) begin
      failures++; $display("FAIL reset_flags busy=%b done=%b want 0 0", bus3.busy_o, bus3.done_o);
    end
    checks++;
    if (bus3.move_o !== 4'd0 || bus3.move_score_o !== 4'd0 ||
        bus3.no_move_o !== 1'b0 || bus3.bad_board_o !== 1'b0) begin
      failures++; $display("FAIL reset_result move=%0d score=%0d no_move=%b bad=%b want all 0",
                           bus3.move_o, bus3.move_score_o, bus3.no_move_o, bus3.bad_board_o);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_empty_board();
    int lat;
    run3(18'd0, lat);
    checks++;
    if (lat !== 10) begin failures++; $display("FAIL empty_latency got=%0d want=10", lat); end
    checks++;
    if (bus3.move_o !== 4'd4 || bus3.move_score_o !== 4'd4) begin
      failures++; $display("FAIL empty_move got move=%0d score=%0d want 4 4", bus3.move_o, bus3.move_score_o);
    end
    checks++;
    if (bus3.no_move_o !== 1'b0 || bus3.busy_o !== 1'b1) begin
      failures++; $display("FAIL empty_flags got no_move=%b busy=%b want 0 1", bus3.no_move_o, bus3.busy_o);
    end
    @(posedge clk); #1;
    checks++;
    if (bus3.done_o !== 1'b0 || bus3.busy_o !== 1'b0 || bus3.move_o !== 4'd4) begin
      failures++; $display("FAIL empty_after got done=%b busy=%b move=%0d want 0 0 4",
                           bus3.done_o, bus3.busy_o, bus3.move_o);
    end
  endtask

  task automatic test_abort();
    int seen;
    repeat (2) @(negedge clk);
    bus3.board_i = 18'd0;
    bus3.start_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_i = 1'b0;
    checks++;
    if (bus3.busy_o !== 1'b1) begin failures++; $display("FAIL abort_busy_start got=%b want=1", bus3.busy_o); end
    repeat (4) begin @(posedge clk); #1; end
    bus3.abort_i = 1'b1;
    @(posedge clk); #1;
    bus3.abort_i = 1'b0;
    checks++;
    if (bus3.busy_o !== 1'b0) begin failures++; $display("FAIL abort_busy_low got=%b want=0", bus3.busy_o); end
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus3.done_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses want=0", seen); end
    checks++;
    if (bus3.move_o !== 4'd4 || bus3.move_score_o !== 4'd4) begin
      failures++; $display("FAIL abort_hold got move=%0d score=%0d want 4 4", bus3.move_o, bus3.move_score_o);
    end
    $display("abort at k=4 done_pulses=%0d", seen);
  endtask

  task automatic test_win();
    int lat;
    logic [17:0] b;
    b = put3(put3(put3(put3(18'd0, 0, AI), 1, AI), 3, PL), 4, PL);
    run3(b, lat);
    checks++;
    if (lat !== 10 || bus3.move_o !== 4'd2 || bus3.move_score_o !== 4'd15) begin
      failures++; $display("FAIL win got lat=%0d move=%0d score=%0d want 10 2 15",
                           lat, bus3.move_o, bus3.move_score_o);
    end
  endtask

  task automatic test_block();
    int lat;
    int exp_move;
    int exp_score;
    logic [17:0] b;
`ifdef AI_BLOCK_EN
    exp_move  = 8;
    exp_score = 12;
`else
    exp_move  = 0;
    exp_score = 3;
`endif
    b = put3(put3(put3(18'd0, 6, PL), 7, PL), 4, AI);
    run3(b, lat);
    checks++;
    if (int'(bus3.move_o) !== exp_move || int'(bus3.move_score_o) !== exp_score) begin
      failures++; $display("FAIL block got move=%0d score=%0d want %0d %0d",
                           bus3.move_o, bus3.move_score_o, exp_move, exp_score);
    end
  endtask

  task automatic test_full_board();
    int lat;
    logic [17:0] b;
    b = 18'd0;
    b = put3(b, 0, AI); b = put3(b, 1, PL); b = put3(b, 2, AI);
    b = put3(b, 3, AI); b = put3(b, 4, PL); b = put3(b, 5, PL);
    b = put3(b, 6, PL); b = put3(b, 7, AI); b = put3(b, 8, AI);
    run3(b, lat);
    checks++;
    if (bus3.no_move_o !== 1'b1 || bus3.move_o !== 4'd0 || bus3.move_score_o !== 4'd0) begin
      failures++; $display("FAIL full_board got no_move=%b move=%0d score=%0d want 1 0 0",
                           bus3.no_move_o, bus3.move_o, bus3.move_score_o);
    end
  endtask

  task automatic test_bad_board();
    int lat;
    run3(put3(18'd0, 5, BAD), lat);
    checks++;
    if (bus3.bad_board_o !== 1'b1 || bus3.move_o !== 4'd0 || bus3.move_score_o !== 4'd0) begin
      failures++; $display("FAIL bad_board got bad=%b move=%0d score=%0d want 1 0 0",
                           bus3.bad_board_o, bus3.move_o, bus3.move_score_o);
    end
  endtask

  task automatic test_start_while_busy();
    int lat;
    int extra;
    logic [17:0] b;
    b = put3(put3(put3(put3(18'd0, 0, AI), 1, AI), 3, PL), 4, PL);
    repeat (2) @(negedge clk);
    bus3.board_i = b;
    bus3.start_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_i = 1'b0;
    lat = 0;
    while (lat < 40 && bus3.done_o !== 1'b1) begin
      bus3.start_i = (lat == 3);
      bus3.board_i = (lat == 3) ? 18'd0 : '1;
      @(posedge clk); #1;
      lat++;
    end
    bus3.start_i = 1'b0;
    checks++;
    if (lat !== 10 || bus3.move_o !== 4'd2 || bus3.move_score_o !== 4'd15) begin
      failures++; $display("FAIL busy_start got lat=%0d move=%0d score=%0d want 10 2 15",
                           lat, bus3.move_o, bus3.move_score_o);
    end
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus3.done_o === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin failures++; $display("FAIL busy_start_queued got=%0d pulses want=0", extra); end
    $display("start while busy lat=%0d extra_done=%0d", lat, extra);
  endtask

  task automatic test_start_abort_idle();
    int lat;
    repeat (2) @(negedge clk);
    bus3.board_i = 18'd0;
    bus3.start_i = 1'b1;
    bus3.abort_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_i = 1'b0;
    bus3.abort_i = 1'b0;
    lat = 0;
    while (lat < 40 && bus3.done_o !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 10 || bus3.move_o !== 4'd4) begin
      failures++; $display("FAIL start_abort_idle got lat=%0d move=%0d want 10 4", lat, bus3.move_o);
    end
    $display("start+abort in idle lat=%0d move=%0d", lat, bus3.move_o);
  endtask

  task automatic test_async_reset();
    int seen;
    repeat (2) @(negedge clk);
    bus3.board_i = 18'd0;
    bus3.start_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus3.busy_o !== 1'b0 || bus3.done_o !== 1'b0 || bus3.move_o !== 4'd0 ||
        bus3.move_score_o !== 4'd0 || bus3.no_move_o !== 1'b0 || bus3.bad_board_o !== 1'b0) begin
      failures++; $display("FAIL async_reset got busy=%b done=%b move=%0d score=%0d want all 0",
                           bus3.busy_o, bus3.done_o, bus3.move_o, bus3.move_score_o);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus3.done_o === 1'b1 || bus3.busy_o === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL async_reset_idle got=%0d active cycles want=0", seen); end
    $display("async reset mid-scan active_after=%0d", seen);
  endtask

  task automatic test_n4_empty();
    int lat;
    repeat (2) @(negedge clk);
    bus4.board_i = 32'd0;
    bus4.start_i = 1'b1;
    @(posedge clk); #1;
    bus4.start_i = 1'b0;
    bus4.board_i = '1;
    lat = 0;
    while (lat < 60 && bus4.done_o !== 1'b1) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL n4_latency got=%0d want=17", lat); end
    checks++;
    if (bus4.move_o !== 4'd5 || bus4.move_score_o !== 4'd4) begin
      failures++; $display("FAIL n4_move got move=%0d score=%0d want 5 4", bus4.move_o, bus4.move_score_o);
    end
    $display("scan N=4 empty lat=%0d move=%0d score=%0d", lat, bus4.move_o, bus4.move_score_o);
  endtask

  initial begin
    bus3.start_i = 1'b0;
    bus3.abort_i = 1'b0;
    bus3.board_i = '0;
    bus4.start_i = 1'b0;
    bus4.abort_i = 1'b0;
    bus4.board_i = '0;
    test_reset();
    test_empty_board();
    test_abort();
    test_win();
    test_block();
    test_full_board();
    test_bad_board();
    test_start_while_busy();
    test_start_abort_idle();
    test_async_reset();
    test_n4_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
